// File: rtl/uns_6x3_div_pkg.sv
// Shared constants and FSM state type for the 6/3 unsigned divider.
// Widths mirror the 3x3 multiplier: dividend = product, divisor = multiplier.
package uns_6x3_div_pkg;

  localparam int DIVIDEND_WIDTH = 6;
  localparam int DIVISOR_WIDTH  = 3;
  localparam int CNT_WIDTH      = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/uns_div_datapath.sv
// Restoring-division datapath: working registers, subtract-compare
// and the registered quotient/remainder/divide-by-zero outputs.
module uns_div_datapath
  import uns_6x3_div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_ops,
  input  logic                      step,
  input  logic                      load_out,
  input  logic                      is_zero,
  input  logic [DIVIDEND_WIDTH-1:0] n,
  input  logic [DIVISOR_WIDTH-1:0]  d,
  output logic                      last,
  output logic [DIVIDEND_WIDTH-1:0] q_reg,
  output logic [DIVISOR_WIDTH-1:0]  r_reg,
  output logic                      div_zero
);

  logic [DIVISOR_WIDTH-1:0]  rem;
  logic [DIVIDEND_WIDTH-1:0] quo;
  logic [DIVISOR_WIDTH-1:0]  div;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      dz;

  logic [DIVISOR_WIDTH:0]   t;
  logic [DIVISOR_WIDTH:0]   diff;
  logic                     qbit;
  logic [DIVISOR_WIDTH-1:0] rem_next;

  // One extra bit on t so the shifted remainder never overflows.
  always_comb begin
    t        = {rem, quo[DIVIDEND_WIDTH-1]};
    diff     = t - {1'b0, div};
    qbit     = (t >= {1'b0, div});
    rem_next = qbit ? diff[DIVISOR_WIDTH-1:0]
                    : t[DIVISOR_WIDTH-1:0];
  end

  assign last = (cnt == CNT_WIDTH'(DIVIDEND_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      div <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else if (load_ops) begin
      if (is_zero) begin
        dz <= 1'b1;
      end else begin
        quo <= n;
        div <= d;
        rem <= '0;
        cnt <= '0;
      end
    end else if (step) begin
      rem <= rem_next;
      quo <= {quo[DIVIDEND_WIDTH-2:0], qbit};
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (load_out) begin
      dz <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      div_zero <= 1'b0;
    end else if (load_out) begin
      if (dz) begin
        q_reg    <= '1;
        r_reg    <= '0;
        div_zero <= 1'b1;
      end else begin
        q_reg    <= quo;
        r_reg    <= rem;
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uns_6x3_div.sv
// 6-bit by 3-bit unsigned restoring divider, one quotient bit per clock,
// with the same GO/READY handshake as the 3x3 multiplier.
module uns_6x3_div
  import uns_6x3_div_pkg::*;
(
  input  logic                      SYS_CLOCK,
  input  logic                      FSM_ARESET,
  input  logic                      GO,
  input  logic [DIVIDEND_WIDTH-1:0] N,
  input  logic [DIVISOR_WIDTH-1:0]  D,
  output logic [DIVIDEND_WIDTH-1:0] Q_REG,
  output logic [DIVISOR_WIDTH-1:0]  R_REG,
  output logic                      DIV_ZERO,
  output logic                      READY
);

  div_state_t state;
  div_state_t state_next;

  logic load_ops;
  logic step;
  logic load_out;
  logic is_zero;
  logic last;

  always_ff @(posedge SYS_CLOCK or posedge FSM_ARESET) begin
    if (FSM_ARESET) state <= IDLE;
    else            state <= state_next;
  end

  assign is_zero = (D == '0);

  always_comb begin
    state_next = state;
    load_ops   = 1'b0;
    step       = 1'b0;
    load_out   = 1'b0;
    READY      = 1'b0;
    unique case (state)
      IDLE: begin
        READY = 1'b1;
        if (GO) begin
          load_ops   = 1'b1;
          state_next = is_zero ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        load_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  uns_div_datapath u_dp (
    .clk      (SYS_CLOCK),
    .rst      (FSM_ARESET),
    .load_ops (load_ops),
    .step     (step),
    .load_out (load_out),
    .is_zero  (is_zero),
    .n        (N),
    .d        (D),
    .last     (last),
    .q_reg    (Q_REG),
    .r_reg    (R_REG),
    .div_zero (DIV_ZERO)
  );

endmodule

// File: tb/tb_uns_6x3_div.sv
// Directed and exhaustive bench for uns_6x3_div with a result scoreboard.
// Expected quotient/remainder come from integer / and %.
module tb_uns_6x3_div;

  typedef struct {
    int q;
    int r;
    int dz;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go  = 1'b0;
  logic [5:0] n   = '0;
  logic [2:0] d   = '0;
  logic [5:0] q_reg;
  logic [2:0] r_reg;
  logic       div_zero;
  logic       ready;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t prev;

  always #5 clk = ~clk;

  uns_6x3_div dut (
    .SYS_CLOCK  (clk),
    .FSM_ARESET (rst),
    .GO         (go),
    .N          (n),
    .D          (d),
    .Q_REG      (q_reg),
    .R_REG      (r_reg),
    .DIV_ZERO   (div_zero),
    .READY      (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int nn, input int dd);
    exp_t e;
    if (dd == 0) begin
      e.q = 63; e.r = 0; e.dz = 1; e.lat = 1;
    end else begin
      e.q = nn / dd; e.r = nn % dd; e.dz = 0; e.lat = 7;
    end
    return e;
  endfunction

  // Called at a negedge with READY high; hold keeps GO asserted throughout.
  task automatic run(input int nn, input int dd, input bit hold);
    exp_t e;
    int busy;
    bit tout;
    n  = 6'(nn);
    d  = 3'(dd);
    go = 1'b1;
    sb.push_back(model(nn, dd));
    @(posedge clk);
    #1;
    if (!hold) go = 1'b0;
    busy = 0;
    tout = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      busy++;
      if (busy == 1) begin
        check("hold_q", 32'(q_reg), 32'(prev.q));
        check("hold_r", 32'(r_reg), 32'(prev.r));
        check("hold_dz", 32'(div_zero), 32'(prev.dz));
      end
      n = 6'($urandom);
      d = 3'($urandom);
      if (!hold) go = 1'($urandom);
      if (busy > 20) begin
        tout = 1;
        break;
      end
    end
    if (!hold) go = 1'b0;
    check("timeout", 32'(tout), 32'd0);
    e = sb.pop_front();
    check("lat", 32'(busy), 32'(e.lat));
    check("q", 32'(q_reg), 32'(e.q));
    check("r", 32'(r_reg), 32'(e.r));
    check("dz", 32'(div_zero), 32'(e.dz));
    if (dd != 0) begin
      check("invariant", 32'(int'(q_reg) * dd + int'(r_reg)), 32'(nn));
      check("r_lt_d", 32'(int'(r_reg) < dd), 32'd1);
    end
    prev = e;
  endtask

  initial begin
    prev = '{0, 0, 0, 0};
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_q", 32'(q_reg), 32'd0);
    check("rst_r", 32'(r_reg), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(45, 6, 0);
    run(63, 1, 0);
    run(63, 7, 0);
    run(5, 7, 0);
    run(0, 3, 0);
    run(20, 0, 0);
    run(20, 3, 0);

    run(33, 4, 1);
    run(17, 5, 1);
    run(40, 0, 1);
    run(9, 2, 1);
    run(62, 3, 0);

    n  = 6'd41;
    d  = 3'd5;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_q", 32'(q_reg), 32'd0);
    check("arst_r", 32'(r_reg), 32'd0);
    check("arst_dz", 32'(div_zero), 32'd0);
    prev = '{0, 0, 0, 0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_ready", 32'(ready), 32'd1);
    run(50, 7, 0);

    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 8; j++) begin
        run(i, j, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
